// File: rtl/sopc_ctrl_pkg.sv
// Shared types and defaults for the SOPC reset-sequencing / run-control block.
package sopc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } ctrl_state_e;

  localparam int DEF_HOLD      = 5;
  localparam int DEF_STAGGER   = 2;
  localparam int DEF_RUN_LIMIT = 50;

  // Ceiling log2, used to size the sequencing counter.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sopc_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sopc_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_nxt
);

  logic [W-1:0] r_cnt;

  assign o_nxt = (&r_cnt) ? r_cnt : r_cnt + W'(1);
  assign o_cnt = r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr)     r_cnt <= '0;
    else if (i_en) r_cnt <= o_nxt;
  end

endmodule

// File: rtl/sopc_reset_run_ctrl.sv
// Holds all reset domains, releases them in staggered order, then times the
// run until a halt request or the cycle limit ends it.
module sopc_reset_run_ctrl
  import sopc_ctrl_pkg::*;
#(
  parameter int NUM_RST     = 2,
  parameter int HOLD_CYCLES = DEF_HOLD,
  parameter int STAGGER     = DEF_STAGGER,
  parameter int RUN_LIMIT   = DEF_RUN_LIMIT,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart_i,
  input  logic               halt_req_i,
  input  logic               free_run_i,
  output logic [NUM_RST-1:0] rst_out,
  output logic               running_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic [CNT_W-1:0]   cycle_cnt_o
);

  localparam int LAST_REL = HOLD_CYCLES + (NUM_RST - 1) * STAGGER;
  localparam int HW       = clog2(LAST_REL + 2) + 1;

  ctrl_state_e        r_state, w_state_nxt;
  logic [NUM_RST-1:0] r_rst_out, w_rst_nxt, w_rel_hit;
  logic               r_running, r_done, r_timeout, w_timeout_nxt;
  logic [HW-1:0]      w_hold_cnt, w_hold_nxt;
  logic [CNT_W-1:0]   w_run_nxt;
  logic               w_in_seq, w_limit_hit;

  assign w_in_seq    = (r_state == ST_HOLD) || (r_state == ST_RELEASE);
  assign w_limit_hit = !free_run_i && (w_run_nxt == CNT_W'(RUN_LIMIT));

  // Hold counter keeps counting edges through RELEASE so every domain's
  // release point is a fixed edge number from the start of the sequence.
  sopc_sat_counter #(.W(HW)) u_hold_cnt (
    .clk   (clk),
    .i_clr (rst | restart_i),
    .i_en  (w_in_seq),
    .o_cnt (w_hold_cnt),
    .o_nxt (w_hold_nxt)
  );

  sopc_sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk   (clk),
    .i_clr (rst | restart_i | w_in_seq),
    .i_en  (r_state == ST_RUN),
    .o_cnt (cycle_cnt_o),
    .o_nxt (w_run_nxt)
  );

  for (genvar k = 0; k < NUM_RST; k++) begin : g_rel
    assign w_rel_hit[k] = w_in_seq && (w_hold_nxt == HW'(HOLD_CYCLES + k * STAGGER));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_HOLD;
      r_rst_out <= '1;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rst_out <= w_rst_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_done    <= (w_state_nxt == ST_DONE);
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_HOLD:    if (w_hold_nxt == HW'(HOLD_CYCLES)) w_state_nxt = ST_RELEASE;
      ST_RELEASE: if (w_hold_cnt == HW'(LAST_REL))    w_state_nxt = ST_RUN;
      ST_RUN:     if (halt_req_i || w_limit_hit)      w_state_nxt = ST_DONE;
      default:    w_state_nxt = r_state;
    endcase
    if (restart_i) w_state_nxt = ST_HOLD;
  end

  // A halted run is never a timeout, even when the limit lands on the same edge.
  always_comb begin
    w_rst_nxt     = r_rst_out & ~w_rel_hit;
    w_timeout_nxt = r_timeout;
    if (restart_i) begin
      w_rst_nxt     = '1;
      w_timeout_nxt = 1'b0;
    end else if (r_state == ST_RUN && w_state_nxt == ST_DONE) begin
      w_rst_nxt     = '1;
      w_timeout_nxt = !halt_req_i;
    end
  end

  assign rst_out   = r_rst_out;
  assign running_o = r_running;
  assign done_o    = r_done;
  assign timeout_o = r_timeout;

endmodule
